// File: rtl/food_tracker.sv
// food_tracker: consumer end of the food-coordinate interface.
// Samples the free-running candidate coordinates, latches a stable,
// non-overlapping candidate as the live food, detects the snake head
// eating it, keeps a saturating score and drives the per-pixel food flag.
module food_tracker #(
  parameter int FOOD_SIZE  = 6,
  parameter int HIT_RADIUS = 6,
  parameter int COOLDOWN   = 8,
  parameter int SCORE_W    = 8
) (
  input  logic               clk1,
  input  logic               rst1_n,
  input  logic [9:0]         cand_x,
  input  logic [9:0]         cand_y,
  input  logic [9:0]         head_x,
  input  logic [9:0]         head_y,
  input  logic               head_valid,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic [9:0]         food_x,
  output logic [9:0]         food_y,
  output logic               food_valid,
  output logic               eat_pulse,
  output logic [SCORE_W-1:0] score,
  output logic               draw_food
);

  localparam int                 CNT_W     = $clog2(COOLDOWN + 1);
  localparam logic [10:0]        SIZE_EXT  = 11'(FOOD_SIZE);
  localparam logic [10:0]        RAD_EXT   = 11'(HIT_RADIUS);
  localparam logic [CNT_W-1:0]   COOL_LOAD = CNT_W'(COOLDOWN - 1);
  localparam logic [CNT_W-1:0]   CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);

  typedef enum logic [1:0] {
    S_ACQ  = 2'd0,
    S_LIVE = 2'd1,
    S_COOL = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [9:0]         prev_x_r;
  logic [9:0]         prev_y_r;
  logic [9:0]         head_st_x_r;
  logic [9:0]         head_st_y_r;
  logic [CNT_W-1:0]   cool_cnt_r;
  logic [9:0]         food_x_r;
  logic [9:0]         food_y_r;
  logic               food_valid_r;
  logic               eat_pulse_r;
  logic [SCORE_W-1:0] score_r;
  logic               draw_food_r;

  logic               stable_s;
  logic               overlap_head_s;
  logic               hit_s;
  logic               accept_s;
  logic               eat_s;
  logic               in_x_s;
  logic               in_y_s;

  // Unsigned distance, widened to 11 bits so it can never wrap.
  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] d;
    if (a >= b) begin
      d = {1'b0, a} - {1'b0, b};
    end else begin
      d = {1'b0, b} - {1'b0, a};
    end
    return d;
  endfunction

  // Two points are "near" when both axis distances are inside the hit radius.
  function automatic logic is_near(input logic [9:0] ax, input logic [9:0] ay,
                                   input logic [9:0] bx, input logic [9:0] by);
    return (abs_diff(ax, bx) < RAD_EXT) && (abs_diff(ay, by) < RAD_EXT);
  endfunction

  assign stable_s       = (cand_x == prev_x_r) && (cand_y == prev_y_r);
  assign overlap_head_s = is_near(cand_x, cand_y, head_st_x_r, head_st_y_r);
  assign hit_s          = is_near(head_x, head_y, food_x_r, food_y_r);
  assign in_x_s         = ({1'b0, pix_x} >= {1'b0, food_x_r}) &&
                          ({1'b0, pix_x} <  ({1'b0, food_x_r} + SIZE_EXT));
  assign in_y_s         = ({1'b0, pix_y} >= {1'b0, food_y_r}) &&
                          ({1'b0, pix_y} <  ({1'b0, food_y_r} + SIZE_EXT));

  // State register.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      state_r <= S_ACQ;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic: acquire, live until eaten, then fixed cooldown.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_ACQ: begin
        if (accept_s) begin
          state_next_s = S_LIVE;
        end else begin
          state_next_s = S_ACQ;
        end
      end
      S_LIVE: begin
        if (eat_s) begin
          state_next_s = S_COOL;
        end else begin
          state_next_s = S_LIVE;
        end
      end
      S_COOL: begin
        if (cool_cnt_r == CNT_ZERO) begin
          state_next_s = S_ACQ;
        end else begin
          state_next_s = S_COOL;
        end
      end
      default: state_next_s = S_ACQ;
    endcase
  end

  // Event decode: accept only in S_ACQ, eat only when already in S_LIVE.
  always_comb begin
    accept_s = 1'b0;
    eat_s    = 1'b0;
    case (state_r)
      S_ACQ:   accept_s = stable_s && !overlap_head_s;
      S_LIVE:  eat_s    = head_valid && hit_s;
      S_COOL: begin
        accept_s = 1'b0;
        eat_s    = 1'b0;
      end
      default: begin
        accept_s = 1'b0;
        eat_s    = 1'b0;
      end
    endcase
  end

  // Candidate sample stage; comparing against it rejects torn coordinates.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      prev_x_r <= 10'd0;
      prev_y_r <= 10'd0;
    end else begin
      prev_x_r <= cand_x;
      prev_y_r <= cand_y;
    end
  end

  // Last head position, used to keep new food off the snake head.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      head_st_x_r <= 10'd0;
      head_st_y_r <= 10'd0;
    end else if (head_valid && (state_r != S_COOL)) begin
      head_st_x_r <= head_x;
      head_st_y_r <= head_y;
    end
  end

  // Live food position and validity.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      food_x_r     <= 10'd0;
      food_y_r     <= 10'd0;
      food_valid_r <= 1'b0;
    end else if (accept_s) begin
      food_x_r     <= cand_x;
      food_y_r     <= cand_y;
      food_valid_r <= 1'b1;
    end else if (eat_s) begin
      food_valid_r <= 1'b0;
    end
  end

  // Eat strobe and saturating score counter.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      eat_pulse_r <= 1'b0;
      score_r     <= {SCORE_W{1'b0}};
    end else begin
      eat_pulse_r <= eat_s;
      if (eat_s && (score_r != SCORE_MAX)) begin
        score_r <= score_r + SCORE_ONE;
      end
    end
  end

  // Cooldown counter: loaded on eat, counts down while cooling.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      cool_cnt_r <= CNT_ZERO;
    end else if (eat_s) begin
      cool_cnt_r <= COOL_LOAD;
    end else if ((state_r == S_COOL) && (cool_cnt_r != CNT_ZERO)) begin
      cool_cnt_r <= cool_cnt_r - CNT_ONE;
    end
  end

  // Registered per-pixel food flag for the colour mux.
  always_ff @(posedge clk1 or negedge rst1_n) begin
    if (!rst1_n) begin
      draw_food_r <= 1'b0;
    end else begin
      draw_food_r <= food_valid_r && in_x_s && in_y_s;
    end
  end

  assign food_x     = food_x_r;
  assign food_y     = food_y_r;
  assign food_valid = food_valid_r;
  assign eat_pulse  = eat_pulse_r;
  assign score      = score_r;
  assign draw_food  = draw_food_r;

endmodule

// File: tb/tb_food_tracker.sv
// tb_food_tracker: directed stimulus with a queue-based scoreboard.
// Stimulus pushes expected acquisitions, eats and pixel results; a monitor
// pops and compares whenever the DUT presents the corresponding output.
module tb_food_tracker;

  logic       clk1 = 1'b0;
  logic       rst1_n;
  logic [9:0] cand_x, cand_y, head_x, head_y, pix_x, pix_y;
  logic       head_valid;
  logic [9:0] food_x, food_y;
  logic       food_valid, eat_pulse, draw_food;
  logic [7:0] score;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eat_seen = 0;
  int exp_score = 0;
  logic fv_prev = 1'b0;
  logic ep_prev = 1'b0;

  typedef struct { logic [9:0] x; logic [9:0] y; } pos_t;
  typedef struct { int due; logic exp; } pix_t;
  pos_t acq_q[$];
  int   eat_q[$];
  pix_t draw_q[$];

  food_tracker dut (
    .clk1(clk1), .rst1_n(rst1_n),
    .cand_x(cand_x), .cand_y(cand_y),
    .head_x(head_x), .head_y(head_y), .head_valid(head_valid),
    .pix_x(pix_x), .pix_y(pix_y),
    .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
    .eat_pulse(eat_pulse), .score(score), .draw_food(draw_food)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs against the queued expectations.
  always @(negedge clk1) begin
    if (rst1_n === 1'b1) begin
      if (food_valid && !fv_prev) begin
        checks++;
        if (acq_q.size() == 0) begin
          errors++;
          $display("FAIL acq_unexpected got (%0d,%0d) want no acquire", food_x, food_y);
        end else begin
          pos_t e;
          e = acq_q.pop_front();
          if (food_x !== e.x || food_y !== e.y) begin
            errors++;
            $display("FAIL acq_pos got (%0d,%0d) want (%0d,%0d)", food_x, food_y, e.x, e.y);
          end
        end
      end
      if (eat_pulse) begin
        eat_seen++;
        checks++;
        if (eat_q.size() == 0) begin
          errors++;
          $display("FAIL eat_unexpected got score %0d want no eat", score);
        end else begin
          int es;
          es = eat_q.pop_front();
          if (score !== es[7:0] || food_valid !== 1'b0) begin
            errors++;
            $display("FAIL eat_state got score %0d fv %0d want score %0d fv 0",
                     score, food_valid, es);
          end
        end
      end
      if (ep_prev) begin
        checks++;
        if (eat_pulse !== 1'b0) begin
          errors++;
          $display("FAIL eat_width got %0d want 0", eat_pulse);
        end
      end
      while (draw_q.size() > 0 && draw_q[0].due <= cyc) begin
        pix_t p;
        p = draw_q.pop_front();
        checks++;
        if (draw_food !== p.exp) begin
          errors++;
          $display("FAIL draw_food got %0d want %0d", draw_food, p.exp);
        end
      end
    end
    fv_prev = food_valid;
    ep_prev = eat_pulse;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic head_pulse(input logic [9:0] x, input logic [9:0] y);
    head_x = x;
    head_y = y;
    head_valid = 1'b1;
    tick(1);
    head_valid = 1'b0;
  endtask

  task automatic eat_at(input logic [9:0] x, input logic [9:0] y);
    if (exp_score < 255) exp_score++;
    eat_q.push_back(exp_score);
    head_pulse(x, y);
  endtask

  task automatic push_acq(input logic [9:0] x, input logic [9:0] y);
    pos_t p;
    p.x = x;
    p.y = y;
    acq_q.push_back(p);
  endtask

  task automatic pix_probe(input logic [9:0] x, input logic [9:0] y, input logic exp);
    pix_t p;
    pix_x = x;
    pix_y = y;
    p.due = cyc + 1;
    p.exp = exp;
    draw_q.push_back(p);
    tick(1);
  endtask

  task automatic wait_fv(input string name, input int budget);
    int n;
    n = 0;
    while (food_valid !== 1'b1 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, food_valid, 1);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_fx"}, food_x, 0);
    chk({name, "_fy"}, food_y, 0);
    chk({name, "_fv"}, food_valid, 0);
    chk({name, "_eat"}, eat_pulse, 0);
    chk({name, "_score"}, score, 0);
    chk({name, "_draw"}, draw_food, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cur_x, cur_y, nxt_x, nxt_y;
    rst1_n = 1'b0;
    cand_x = 10'd200; cand_y = 10'd150;
    head_x = 10'd0;   head_y = 10'd0;
    head_valid = 1'b0;
    pix_x = 10'd0;    pix_y = 10'd0;
    tick(2);
    check_all_zero("reset");

    // Test 1: steady candidate is latched within three cycles.
    push_acq(10'd200, 10'd150);
    rst1_n = 1'b1;
    head_pulse(10'd50, 10'd50);
    tick(2);
    chk("t1_fv_by_cycle3", food_valid, 1);
    chk("t1_score", score, 0);

    // Test 5: food square boundaries.
    pix_probe(10'd200, 10'd150, 1'b1);
    pix_probe(10'd205, 10'd155, 1'b1);
    pix_probe(10'd206, 10'd150, 1'b0);
    pix_probe(10'd199, 10'd150, 1'b0);
    pix_probe(10'd205, 10'd156, 1'b0);
    pix_probe(10'd203, 10'd152, 1'b1);

    // Test 4: candidate overlapping the stored head is not acquired.
    eat_at(10'd200, 10'd150);
    cand_x = 10'd202; cand_y = 10'd152;
    tick(20);
    chk("t4_no_acq_overlap", food_valid, 0);
    pix_probe(10'd200, 10'd150, 1'b0);
    pix_probe(10'd203, 10'd152, 1'b0);
    push_acq(10'd202, 10'd152);
    head_pulse(10'd100, 10'd100);
    wait_fv("t4_acq_after_move", 10);

    // Test 2: alternating candidate is never stable.
    eat_at(10'd202, 10'd152);
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        cand_x = 10'd300; cand_y = 10'd250;
      end else begin
        cand_x = 10'd200; cand_y = 10'd150;
      end
      tick(1);
    end
    chk("t2_no_acq_unstable", food_valid, 0);
    push_acq(10'd300, 10'd250);
    cand_x = 10'd300; cand_y = 10'd250;
    wait_fv("t2_acq_after_hold", 10);

    // Test 3: distance 6 misses, distance 3 eats, then reacquire.
    head_pulse(10'd306, 10'd250);
    tick(5);
    chk("t3_no_eat_count", eat_seen, 2);
    chk("t3_no_eat_score", score, 2);
    chk("t3_no_eat_fv", food_valid, 1);
    eat_at(10'd303, 10'd247);
    chk("t3_score_after_eat", score, 3);
    push_acq(10'd500, 10'd400);
    cand_x = 10'd500; cand_y = 10'd400;
    wait_fv("t3_reacquire", 30);

    // Test 6: drive the score to saturation, then eat once more.
    cur_x = 10'd500; cur_y = 10'd400;
    while (exp_score < 255) begin
      eat_at(cur_x, cur_y);
      if (cur_x == 10'd500) begin
        nxt_x = 10'd100; nxt_y = 10'd300;
      end else begin
        nxt_x = 10'd500; nxt_y = 10'd400;
      end
      cand_x = nxt_x; cand_y = nxt_y;
      push_acq(nxt_x, nxt_y);
      wait_fv("t6_reacquire", 30);
      cur_x = nxt_x; cur_y = nxt_y;
    end
    chk("t6_score_255", score, 255);
    eat_at(cur_x, cur_y);
    chk("t6_score_saturated", score, 255);
    chk("t6_fv_after_sat_eat", food_valid, 0);
    tick(2);
    rst1_n = 1'b0;
    #1;
    check_all_zero("t6_async_reset");
    tick(3);

    chk("end_acq_q_empty", acq_q.size(), 0);
    chk("end_eat_q_empty", eat_q.size(), 0);
    chk("end_draw_q_empty", draw_q.size(), 0);
    chk("end_eat_count", eat_seen, 256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
